// File: rtl/march_c_mbist.sv
// March C- MBIST controller for a single-port RAM (2^AW x DW, RD_LAT read latency).
// Define MBIST_CHECKERBOARD_EN to append a second pass on a per-address checkerboard background.
module march_c_mbist #(
  parameter int DW     = 4,
  parameter int AW     = 8,
  parameter int RD_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_in,
  input  logic [DW-1:0] dat_in,
  output logic [DW-1:0] dat_out,
  output logic [AW-1:0] addr_out,
  output logic          w_en_out,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [3:0]    fail_elem,
  output logic [7:0]    err_cnt
);

`ifdef MBIST_CHECKERBOARD_EN
  localparam bit CHECKERBOARD = 1'b1;
`else
  localparam bit CHECKERBOARD = 1'b0;
`endif

  localparam int            LW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);

  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, DONE} state_t;

  state_t        state;
  state_t        nxt_state;
  logic          bg;
  logic          nxt_bg;
  logic [LW-1:0] lat_cnt;
  logic [AW-1:0] nxt_addr;
  logic [DW-1:0] nxt_dat;
  logic          running;
  logic          term;
  logic          rd_done;
  logic          mismatch;
  logic          finish;

  // Background word: solid 0 for the first pass, bit i = i[0]^a[0] for the checkerboard pass.
  function automatic logic [DW-1:0] pattern(input logic b, input logic a0, input logic one);
    logic [DW-1:0] p;
    for (int i = 0; i < DW; i++) begin
      p[i] = CHECKERBOARD & b & (i[0] ^ a0);
    end
    return one ? ~p : p;
  endfunction

  function automatic logic is_down(input state_t s);
    return (s == M3) || (s == M4);
  endfunction

  function automatic logic rd_one(input state_t s);
    return (s == M2) || (s == M4);
  endfunction

  function automatic logic wr_one(input state_t s);
    return (s == M1) || (s == M3);
  endfunction

  function automatic logic [2:0] elem_idx(input state_t s);
    case (s)
      M1:      return 3'd1;
      M2:      return 3'd2;
      M3:      return 3'd3;
      M4:      return 3'd4;
      M5:      return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Next cell: step the address, or reload it at the terminal address and move to the next element.
  always_comb begin
    running   = state inside {M0, M1, M2, M3, M4, M5};
    term      = is_down(state) ? (addr_out == '0) : (addr_out == '1);
    rd_done   = running && !w_en_out && (lat_cnt == LAT_LAST);
    mismatch  = rd_done && (dat_in != dat_out);
    nxt_state = state;
    nxt_addr  = addr_out;
    nxt_bg    = bg;
    finish    = 1'b0;
    if (!term) begin
      nxt_addr = is_down(state) ? addr_out - 1'b1 : addr_out + 1'b1;
    end else begin
      case (state)
        M0: begin nxt_state = M1; nxt_addr = '0; end
        M1: begin nxt_state = M2; nxt_addr = '0; end
        M2: begin nxt_state = M3; nxt_addr = '1; end
        M3: begin nxt_state = M4; nxt_addr = '1; end
        M4: begin nxt_state = M5; nxt_addr = '0; end
        M5: begin
          if (CHECKERBOARD && !bg) begin
            nxt_state = M0;
            nxt_addr  = '0;
            nxt_bg    = 1'b1;
          end else begin
            finish = 1'b1;
          end
        end
        default: ;
      endcase
    end
    nxt_dat = pattern(nxt_bg, nxt_addr[0], rd_one(nxt_state));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bg        <= 1'b0;
      lat_cnt   <= '0;
      dat_out   <= '0;
      addr_out  <= '0;
      w_en_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      err_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en_in) begin
            state     <= M0;
            bg        <= 1'b0;
            lat_cnt   <= '0;
            addr_out  <= '0;
            w_en_out  <= 1'b1;
            dat_out   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            err_cnt   <= '0;
          end
        end
        DONE: begin
          if (!en_in) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          if (!en_in) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            addr_out <= '0;
            w_en_out <= 1'b0;
            dat_out  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
          end else begin
            if (mismatch) begin
              err_cnt <= sat_inc(err_cnt);
              if (err_cnt == 8'd0) begin
                fail_addr <= addr_out;
                fail_elem <= {CHECKERBOARD & bg, elem_idx(state)};
              end
            end
            if (w_en_out || rd_done) begin
              lat_cnt <= '0;
              if (!w_en_out && state != M5) begin
                w_en_out <= 1'b1;
                dat_out  <= pattern(bg, addr_out[0], wr_one(state));
              end else if (finish) begin
                state    <= DONE;
                busy     <= 1'b0;
                done     <= 1'b1;
                w_en_out <= 1'b0;
                addr_out <= '0;
                dat_out  <= '0;
                pass     <= (err_cnt == 8'd0) && !mismatch;
              end else begin
                state    <= nxt_state;
                addr_out <= nxt_addr;
                bg       <= nxt_bg;
                w_en_out <= (nxt_state == M0);
                dat_out  <= nxt_dat;
              end
            end else begin
              lat_cnt <= lat_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_march_c_mbist.sv
// Scoreboard bench for march_c_mbist: a March C- op-list model predicts every bus cycle and the final result.
module tb_march_c_mbist;
  localparam int DW     = 4;
  localparam int AW     = 8;
  localparam int RD_LAT = 3;
  localparam int N      = 1 << AW;
`ifdef MBIST_CHECKERBOARD_EN
  localparam int NBG = 2;
`else
  localparam int NBG = 1;
`endif
  localparam int T_EXP = N * (1 + 4 * (RD_LAT + 1) + RD_LAT) * NBG;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_in;
  logic [DW-1:0] dat_in;
  logic [DW-1:0] dat_out;
  logic [AW-1:0] addr_out;
  logic          w_en_out;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW-1:0] fail_addr;
  logic [3:0]    fail_elem;
  logic [7:0]    err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    logic [7:0]    err;
  } op_t;

  typedef struct packed {
    logic          pass;
    logic [7:0]    err;
    logic [AW-1:0] faddr;
    logic [3:0]    felem;
  } res_t;

  op_t  cyc_q[$];
  res_t res_q[$];

  logic          fault_en;
  logic          fault_all;
  logic          fault_sa1;
  logic [AW-1:0] fault_addr;
  logic [DW-1:0] fault_mask;

  logic [DW-1:0] mem [N];
  logic [DW-1:0] mdl [N];
  logic [AW-1:0] adly [RD_LAT-1];
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_val;

  int   mon_run;
  logic mon_done_prev;

  march_c_mbist #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .dat_in(dat_in), .dat_out(dat_out),
    .addr_out(addr_out), .w_en_out(w_en_out), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] faulted(input logic [DW-1:0] v, input int a);
    if (fault_en && (fault_all || a == int'(fault_addr)))
      return fault_sa1 ? (v | fault_mask) : (v & ~fault_mask);
    return v;
  endfunction

  // RAM with RD_LAT-cycle read path and stuck-at fault injection on reads
  assign rd_addr = adly[RD_LAT-2];
  always_comb begin
    rd_val = faulted(mem[rd_addr], int'(rd_addr));
    dat_in = rd_val;
  end

  initial begin
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    for (int k = 0; k < RD_LAT - 1; k++) adly[k] = '0;
    forever begin
      @(posedge clk);
      if (w_en_out) mem[addr_out] <= dat_out;
      adly[0] <= addr_out;
      for (int k = 1; k < RD_LAT - 1; k++) adly[k] <= adly[k-1];
    end
  end

  function automatic logic [DW-1:0] bg_word(input int bgi, input int a, input bit one);
    logic [DW-1:0] w;
    for (int i = 0; i < DW; i++) w[i] = (bgi == 1) && ((((i % 2) ^ (a % 2))) == 1);
    return one ? ~w : w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Expected cycle-by-cycle bus activity and final result of one complete run
  task automatic build_expect();
    int err = 0;
    res_t r = '0;
    logic [DW-1:0] rexp;
    int a;
    for (int bgi = 0; bgi < NBG; bgi++) begin
      for (int e = 0; e < 6; e++) begin
        for (int k = 0; k < N; k++) begin
          a = (e == 3 || e == 4) ? (N - 1 - k) : k;
          if (e == 0) begin
            mdl[a] = bg_word(bgi, a, 1'b0);
            cyc_q.push_back({1'b1, AW'(a), mdl[a], 8'(err)});
          end else begin
            rexp = bg_word(bgi, a, (e == 2 || e == 4));
            for (int c = 0; c < RD_LAT; c++) cyc_q.push_back({1'b0, AW'(a), rexp, 8'(err)});
            if (faulted(mdl[a], a) != rexp) begin
              if (err == 0) begin
                r.faddr = AW'(a);
                r.felem = {bgi[0], 3'(e)};
              end
              err = (err < 255) ? err + 1 : 255;
            end
            if (e != 5) begin
              mdl[a] = bg_word(bgi, a, (e == 1 || e == 3));
              cyc_q.push_back({1'b1, AW'(a), mdl[a], 8'(err)});
            end
          end
        end
      end
    end
    r.pass = (err == 0);
    r.err  = 8'(err);
    res_q.push_back(r);
  endtask

  // Monitor: every busy cycle against the scoreboard, and the result when done rises
  initial begin
    op_t  got;
    op_t  exp;
    res_t r;
    mon_run = 0;
    mon_done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy) begin
        mon_run++;
        got = {w_en_out, addr_out, dat_out, err_cnt};
        checks++;
        if (cyc_q.size() == 0) begin
          errors++;
          $display("FAIL op_extra cycle %0d: got we=%0b addr=%0h dat=%0h, required no operation",
                   mon_run, got.we, got.addr, got.dat);
        end else begin
          exp = cyc_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL op cycle %0d: got we=%0b addr=%0h dat=%0h err=%0d, required we=%0b addr=%0h dat=%0h err=%0d",
                     mon_run, got.we, got.addr, got.dat, got.err, exp.we, exp.addr, exp.dat, exp.err);
          end
        end
      end else if (done && !mon_done_prev) begin
        chk("run_cycles", mon_run, T_EXP);
        chk("ops_left", cyc_q.size(), 0);
        if (res_q.size() == 0) begin
          chk("result_expected", 0, 1);
        end else begin
          r = res_q.pop_front();
          chk("result_pass", pass, r.pass);
          chk("result_err_cnt", err_cnt, r.err);
          chk("result_fail_addr", fail_addr, r.faddr);
          chk("result_fail_elem", fail_elem, r.felem);
        end
        mon_run = 0;
      end else begin
        mon_run = 0;
      end
      mon_done_prev = done;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_dat_out"}, dat_out, 0);
    chk({tag, "_addr_out"}, addr_out, 0);
    chk({tag, "_w_en_out"}, w_en_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_fail_addr"}, fail_addr, 0);
    chk({tag, "_fail_elem"}, fail_elem, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < T_EXP + 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, done, 1);
  endtask

  task automatic do_run(input string tag);
    build_expect();
    en_in = 1'b1;
    wait_done(tag);
  endtask

  task automatic finish_run();
    en_in = 1'b0;
    @(negedge clk);
    chk("release_done", done, 0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    en_in = 1'b0;
    fault_en = 1'b0;
    fault_all = 1'b0;
    fault_sa1 = 1'b0;
    fault_addr = '0;
    fault_mask = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle");

    do_run("clean");
    chk("clean_pass", pass, 1);
    chk("clean_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("done_hold", done, 1);
    en_in = 1'b0;
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_pass_held", pass, 1);
    @(negedge clk);

    fault_en = 1'b1;
    fault_addr = 8'h37;
    fault_mask = 4'b0100;
    fault_sa1 = 1'b1;
    do_run("sa1_b2");
    chk("sa1_fail_addr", fail_addr, 32'h37);
    chk("sa1_fail_elem", fail_elem, 32'h1);
    chk("sa1_err_cnt", err_cnt, (NBG == 1) ? 3 : 5);
    chk("sa1_pass", pass, 0);
    finish_run();

    fault_addr = AW'($urandom_range(0, N - 1));
    fault_mask = DW'($urandom_range(1, (1 << DW) - 1));
    fault_sa1 = 1'($urandom_range(0, 1));
    do_run("rand_fault");
    finish_run();

    fault_all = 1'b1;
    fault_sa1 = 1'b1;
    fault_mask = DW'(1 << $urandom_range(0, DW - 1));
    do_run("all_sa1");
    chk("sat_err_cnt", err_cnt, 255);
    chk("sat_fail_addr", fail_addr, 0);
    chk("sat_fail_elem", fail_elem, 1);
    finish_run();
    fault_all = 1'b0;

    fault_addr = 8'h10;
    fault_mask = 4'b0001;
    fault_sa1 = 1'b1;
    build_expect();
    en_in = 1'b1;
    repeat (1000) @(negedge clk);
    chk("pre_abort_err", err_cnt, 1);
    en_in = 1'b0;
    @(negedge clk);
    chk("abort_w_en", w_en_out, 0);
    chk("abort_addr", addr_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    cyc_q.delete();
    res_q.delete();
    build_expect();
    en_in = 1'b1;
    @(negedge clk);
    chk("restart_err", err_cnt, 0);
    chk("restart_busy", busy, 1);
    wait_done("restart");
    chk("restart_final_err", err_cnt, 3 * NBG);
    finish_run();

    fault_en = 1'b0;
    build_expect();
    en_in = 1'b1;
    repeat (3000) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    cyc_q.delete();
    res_q.delete();
    build_expect();
    rst = 1'b0;
    wait_done("post_reset");
    chk("post_reset_pass", pass, 1);
    finish_run();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
